// File: rtl/vending_pkg.sv
// Shared types and constants for the vending credit controller.
// Holds the FSM state encoding, default geometry and the price-table lookup.
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } state_e;

   localparam int unsigned DEF_CREDIT_W     = 8;
   localparam int unsigned DEF_NUM_PRODUCTS = 4;
   localparam int unsigned DEF_SEL_W        = 2;

   localparam logic [DEF_NUM_PRODUCTS*DEF_CREDIT_W-1:0] DEF_PRICES =
      {8'd200, 8'd120, 8'd100, 8'd50};

   // Lookup works on a table widened to the largest supported geometry.
   localparam int unsigned MAX_CREDIT_W = 32;
   localparam int unsigned MAX_PRODUCTS = 16;
   localparam int unsigned PRICE_TBL_W  = MAX_PRODUCTS * MAX_CREDIT_W;

   function automatic logic [MAX_CREDIT_W-1:0] price_lookup(
      input logic [PRICE_TBL_W-1:0] prices,
      input int unsigned            idx,
      input int unsigned            credit_w
   );
      logic [PRICE_TBL_W-1:0]  shifted;
      logic [MAX_CREDIT_W-1:0] mask;
      shifted = prices >> (idx * credit_w);
      mask    = (credit_w >= MAX_CREDIT_W) ? '1
              : ((MAX_CREDIT_W'(1) << credit_w) - MAX_CREDIT_W'(1));
      return shifted[MAX_CREDIT_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/vending_credit_controller_if.sv
// Front-end / back-end signal bundle of the vending credit controller.
// master = coin acceptor, keypad and driver side; slave = the controller.
interface vending_credit_controller_if
   import vending_pkg::*;
#(
   parameter int unsigned CREDIT_W = DEF_CREDIT_W,
   parameter int unsigned SEL_W    = DEF_SEL_W
);

   logic                coin_valid;
   logic [CREDIT_W-1:0] coin_value;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel_id;
   logic                cancel;

   logic                coin_reject;
   logic                sel_reject;
   logic                vend_valid;
   logic [SEL_W-1:0]    vend_id;
   logic                change_pulse;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport master (
      output coin_valid, coin_value, sel_valid, sel_id, cancel,
      input  coin_reject, sel_reject, vend_valid, vend_id,
             change_pulse, credit, busy
   );

   modport slave (
      input  coin_valid, coin_value, sel_valid, sel_id, cancel,
      output coin_reject, sel_reject, vend_valid, vend_id,
             change_pulse, credit, busy
   );

endinterface

// File: rtl/vending_timeout_counter.sv
// Inactivity timer: counts enabled cycles, flags the last one of TIMEOUT_CYC.
// expire_c is combinational so the FSM can leave CREDIT on that same edge.
module vending_timeout_counter #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

   assign expire_c = enable && (count == LAST);

endmodule

// File: rtl/vending_credit_controller.sv
// Multi-product vending controller: coin credit, priced selection, dispense
// strobe and change returned as a train of CHANGE_UNIT pulses.
module vending_credit_controller
   import vending_pkg::*;
#(
   parameter int unsigned                        CREDIT_W     = DEF_CREDIT_W,
   parameter int unsigned                        NUM_PRODUCTS = DEF_NUM_PRODUCTS,
   parameter int unsigned                        SEL_W        = DEF_SEL_W,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]   PRICES       = DEF_PRICES,
   parameter int unsigned                        CHANGE_UNIT  = 10,
   parameter int unsigned                        TIMEOUT_CYC  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   vending_credit_controller_if.slave   bus
);

   localparam int unsigned SUM_W = CREDIT_W + 1;
   localparam logic [CREDIT_W-1:0]    UNIT      = CREDIT_W'(CHANGE_UNIT);
   localparam logic [PRICE_TBL_W-1:0] PRICE_TBL = PRICE_TBL_W'(PRICES);

   state_e state;
   state_e next_state;

   logic [CREDIT_W-1:0] credit_q,     credit_d;
   logic [SEL_W-1:0]    vend_id_q,    vend_id_d;
   logic                coin_rej_q,   coin_rej_d;
   logic                sel_rej_q,    sel_rej_d;
   logic                vend_q,       vend_d;
   logic                pulse_q,      pulse_d;
   logic                busy_q,       busy_d;

   // Credit datapath helpers
   logic [SUM_W-1:0]    coin_sum;
   logic                coin_ovf;
   logic [CREDIT_W-1:0] sel_price;
   logic                sel_ok;
   logic                has_change;
   logic                has_credit;
   logic                idle_tick;
   logic                expire_c;

   assign coin_sum   = {1'b0, credit_q} + {1'b0, bus.coin_value};
   assign coin_ovf   = coin_sum[CREDIT_W];
   assign sel_price  = CREDIT_W'(price_lookup(PRICE_TBL, 32'(bus.sel_id), CREDIT_W));
   assign sel_ok     = (32'(bus.sel_id) < NUM_PRODUCTS) && (credit_q >= sel_price);
   assign has_change = credit_q >= UNIT;
   assign has_credit = credit_q != '0;
   assign idle_tick  = (state == ST_CREDIT) && !bus.cancel && !bus.coin_valid && !bus.sel_valid;

   // Any activity, or being outside CREDIT, restarts the inactivity window
   vending_timeout_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear    (!idle_tick),
      .enable   (idle_tick),
      .expire_c (expire_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state; cancel outranks coin, coin outranks selection
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (bus.coin_valid) begin
               next_state = ST_CREDIT;
            end
         end
         ST_CREDIT: begin
            if (bus.cancel) begin
               next_state = has_credit ? ST_CHANGE : ST_IDLE;
            end else if (bus.coin_valid) begin
               next_state = ST_CREDIT;
            end else if (bus.sel_valid && sel_ok) begin
               next_state = ST_VEND;
            end else if (expire_c) begin
               next_state = has_credit ? ST_CHANGE : ST_IDLE;
            end
         end
         ST_VEND:   next_state = has_change ? ST_CHANGE : ST_IDLE;
         ST_CHANGE: next_state = has_change ? ST_CHANGE : ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Next values of the credit register and of every registered output
   always_comb begin
      credit_d   = credit_q;
      vend_id_d  = vend_id_q;
      coin_rej_d = 1'b0;
      sel_rej_d  = 1'b0;
      pulse_d    = 1'b0;
      vend_d     = (next_state == ST_VEND);
      busy_d     = (next_state == ST_VEND) || (next_state == ST_CHANGE);

      case (state)
         ST_IDLE: begin
            if (bus.coin_valid) begin
               credit_d = bus.coin_value;
            end
            if (bus.sel_valid) begin
               sel_rej_d = 1'b1;
            end
         end
         ST_CREDIT: begin
            if (bus.cancel) begin
               credit_d = credit_q;
            end else if (bus.coin_valid) begin
               if (coin_ovf) begin
                  coin_rej_d = 1'b1;
               end else begin
                  credit_d = coin_sum[CREDIT_W-1:0];
               end
               sel_rej_d = bus.sel_valid;
            end else if (bus.sel_valid) begin
               if (sel_ok) begin
                  credit_d  = credit_q - sel_price;
                  vend_id_d = bus.sel_id;
               end else begin
                  sel_rej_d = 1'b1;
               end
            end
         end
         ST_VEND, ST_CHANGE: begin
            coin_rej_d = bus.coin_valid;
            sel_rej_d  = bus.sel_valid;
            if (!has_change) begin
               credit_d = '0;
            end
         end
         default: credit_d = '0;
      endcase

      // A pulse goes out on every edge that lands in CHANGE with a unit left
      if ((next_state == ST_CHANGE) && has_change) begin
         pulse_d  = 1'b1;
         credit_d = credit_q - UNIT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_q   <= '0;
         vend_id_q  <= '0;
         coin_rej_q <= 1'b0;
         sel_rej_q  <= 1'b0;
         vend_q     <= 1'b0;
         pulse_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         credit_q   <= credit_d;
         vend_id_q  <= vend_id_d;
         coin_rej_q <= coin_rej_d;
         sel_rej_q  <= sel_rej_d;
         vend_q     <= vend_d;
         pulse_q    <= pulse_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.credit       = credit_q;
   assign bus.vend_id      = vend_id_q;
   assign bus.coin_reject  = coin_rej_q;
   assign bus.sel_reject   = sel_rej_q;
   assign bus.vend_valid   = vend_q;
   assign bus.change_pulse = pulse_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vending_credit_controller.sv
// Scoreboard bench for vending_credit_controller: expected pulse events are
// queued as stimulus is driven and matched as the outputs strobe.
module tb_vending_credit_controller;
   import vending_pkg::*;

   localparam int unsigned CW = 8;
   localparam int unsigned SW = 2;

   localparam logic [3:0] EV_COIN_REJ = 4'd1;
   localparam logic [3:0] EV_SEL_REJ  = 4'd2;
   localparam logic [3:0] EV_VEND     = 4'd3;
   localparam logic [3:0] EV_PULSE    = 4'd4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vending_credit_controller_if #(.CREDIT_W(CW), .SEL_W(SW)) bus  ();
   vending_credit_controller_if #(.CREDIT_W(CW), .SEL_W(SW)) bus2 ();

   vending_credit_controller #(
      .CREDIT_W(CW), .NUM_PRODUCTS(4), .SEL_W(SW), .PRICES(DEF_PRICES),
      .CHANGE_UNIT(10), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   vending_credit_controller #(
      .CREDIT_W(CW), .NUM_PRODUCTS(4), .SEL_W(SW), .PRICES(DEF_PRICES),
      .CHANGE_UNIT(20), .TIMEOUT_CYC(16)
   ) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   logic [7:0] sb_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic sb_push(input logic [3:0] kind, input logic [3:0] id, input int n);
      repeat (n) sb_q.push_back({kind, id});
   endtask

   task automatic sb_observe(input logic [3:0] kind, input logic [3:0] id);
      logic [7:0] exp;
      exp = 8'hFF;
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      check("sb_event", 32'({kind, id}), 32'(exp));
   endtask

   // Monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (bus.coin_reject)  sb_observe(EV_COIN_REJ, 4'd0);
         if (bus.sel_reject)   sb_observe(EV_SEL_REJ, 4'd0);
         if (bus.vend_valid)   sb_observe(EV_VEND, 4'(bus.vend_id));
         if (bus.change_pulse) sb_observe(EV_PULSE, 4'd0);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_coin(input logic [CW-1:0] v);
      bus.coin_valid = 1'b1;
      bus.coin_value = v;
      cycle();
      bus.coin_valid = 1'b0;
   endtask

   task automatic do_sel(input logic [SW-1:0] id);
      bus.sel_valid = 1'b1;
      bus.sel_id    = id;
      cycle();
      bus.sel_valid = 1'b0;
   endtask

   task automatic do_cancel();
      bus.cancel = 1'b1;
      cycle();
      bus.cancel = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (bus.busy && n < budget) begin
         cycle();
         n++;
      end
      check(tag, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int npulse;
      reset = 1'b1;
      bus.coin_valid  = 1'b0; bus.coin_value  = '0; bus.sel_valid  = 1'b0;
      bus.sel_id      = '0;   bus.cancel      = 1'b0;
      bus2.coin_valid = 1'b0; bus2.coin_value = '0; bus2.sel_valid = 1'b0;
      bus2.sel_id     = '0;   bus2.cancel     = 1'b0;
      #2;
      check("rst_credit", 32'(bus.credit), 32'd0);
      check("rst_busy",   32'(bus.busy),   32'd0);
      check("rst_strobes", 32'({bus.vend_valid, bus.change_pulse, bus.coin_reject, bus.sel_reject}), 32'd0);
      cycle(); cycle();
      reset = 1'b0;
      cycle();

      // Exact payment: no change
      do_coin(8'd20);
      do_coin(8'd30);
      check("s1_credit", 32'(bus.credit), 32'd50);
      sb_push(EV_VEND, 4'd0, 1);
      do_sel(2'd0);
      check("s1_vend_valid", 32'(bus.vend_valid), 32'd1);
      check("s1_vend_id",    32'(bus.vend_id),    32'd0);
      check("s1_busy",       32'(bus.busy),       32'd1);
      cycle();
      check("s1_no_pulse", 32'(bus.change_pulse), 32'd0);
      check("s1_idle",     32'(bus.busy),         32'd0);
      check("s1_credit0",  32'(bus.credit),       32'd0);
      check("s1_drain",    32'(sb_q.size()),      32'd0);

      // Overpay: 150 - 120 = 3 units back
      do_coin(8'd100);
      do_coin(8'd50);
      check("s2_credit", 32'(bus.credit), 32'd150);
      sb_push(EV_VEND, 4'd2, 1);
      sb_push(EV_PULSE, 4'd0, 3);
      do_sel(2'd2);
      check("s2_vend_valid", 32'(bus.vend_valid), 32'd1);
      check("s2_credit_after", 32'(bus.credit),   32'd30);
      cycle();
      check("s2_first_pulse", 32'(bus.change_pulse), 32'd1);
      wait_idle(20, "s2_idle_timeout");
      check("s2_credit0", 32'(bus.credit), 32'd0);
      check("s2_drain",   32'(sb_q.size()), 32'd0);

      // Insufficient credit, then cancel refund
      do_coin(8'd50);
      sb_push(EV_SEL_REJ, 4'd0, 1);
      do_sel(2'd3);
      check("s3_sel_reject", 32'(bus.sel_reject), 32'd1);
      check("s3_credit",     32'(bus.credit),     32'd50);
      sb_push(EV_PULSE, 4'd0, 5);
      do_cancel();
      check("s3_cancel_pulse", 32'(bus.change_pulse), 32'd1);
      check("s3_credit_dec",   32'(bus.credit),       32'd40);
      wait_idle(20, "s3_idle_timeout");
      check("s3_credit0", 32'(bus.credit), 32'd0);
      check("s3_drain",   32'(sb_q.size()), 32'd0);

      // Overflow rejection and coin/select collision
      do_coin(8'd200);
      do_coin(8'd50);
      check("s4_credit250", 32'(bus.credit), 32'd250);
      sb_push(EV_COIN_REJ, 4'd0, 1);
      do_coin(8'd10);
      check("s4_coin_reject", 32'(bus.coin_reject), 32'd1);
      check("s4_credit_kept", 32'(bus.credit),      32'd250);
      sb_push(EV_SEL_REJ, 4'd0, 1);
      bus.sel_valid = 1'b1;
      bus.sel_id    = 2'd0;
      do_coin(8'd5);
      bus.sel_valid = 1'b0;
      check("s4_coll_credit", 32'(bus.credit),     32'd255);
      check("s4_coll_selrej", 32'(bus.sel_reject), 32'd1);
      check("s4_coll_busy",   32'(bus.busy),       32'd0);
      sb_push(EV_PULSE, 4'd0, 25);
      do_cancel();
      wait_idle(40, "s4_idle_timeout");
      check("s4_credit0", 32'(bus.credit), 32'd0);
      check("s4_drain",   32'(sb_q.size()), 32'd0);

      // Inactivity timeout refunds after 16 idle cycles
      do_coin(8'd30);
      sb_push(EV_PULSE, 4'd0, 3);
      repeat (15) cycle();
      check("s5_not_yet",    32'(bus.busy),   32'd0);
      check("s5_credit_hold", 32'(bus.credit), 32'd30);
      cycle();
      check("s5_timeout_pulse", 32'(bus.change_pulse), 32'd1);
      check("s5_credit_dec",    32'(bus.credit),       32'd20);
      wait_idle(20, "s5_idle_timeout");
      check("s5_drain", 32'(sb_q.size()), 32'd0);

      // Reset during the second change pulse
      do_coin(8'd40);
      sb_push(EV_PULSE, 4'd0, 2);
      do_cancel();
      cycle();
      check("s6_second_pulse", 32'(bus.change_pulse), 32'd1);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("s6_rst_strobes", 32'({bus.vend_valid, bus.change_pulse, bus.coin_reject, bus.sel_reject}), 32'd0);
      check("s6_rst_credit",  32'(bus.credit), 32'd0);
      check("s6_rst_busy",    32'(bus.busy),   32'd0);
      cycle();
      reset = 1'b0;
      cycle();
      check("s6_drain", 32'(sb_q.size()), 32'd0);
      sb_push(EV_SEL_REJ, 4'd0, 1);
      do_sel(2'd1);
      check("s6_idle_selrej", 32'(bus.sel_reject), 32'd1);
      do_cancel();
      check("s6_idle_cancel", 32'(bus.busy), 32'd0);

      // CHANGE_UNIT=20: 50 refunds two units and drops the residual 10
      bus2.coin_valid = 1'b1;
      bus2.coin_value = 8'd50;
      cycle();
      bus2.coin_valid = 1'b0;
      check("s7_credit", 32'(bus2.credit), 32'd50);
      bus2.cancel = 1'b1;
      cycle();
      bus2.cancel = 1'b0;
      npulse = int'(bus2.change_pulse);
      cycle();
      npulse += int'(bus2.change_pulse);
      check("s7_residual", 32'(bus2.credit), 32'd10);
      for (int i = 0; i < 6; i++) begin
         cycle();
         npulse += int'(bus2.change_pulse);
      end
      check("s7_pulses",  32'(npulse),      32'd2);
      check("s7_credit0", 32'(bus2.credit), 32'd0);
      check("s7_idle",    32'(bus2.busy),   32'd0);

      check("end_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
